process_data_mul_arbiter: RTL

Shares one 29-bit x 4-bit unsigned multiplier core among NUM_REQ requesters in the process_data pipeline. It picks requesters in round-robin order, drives the combinational multiplier, and registers the 32-bit product with the requester index. It presents one result stream with valid/ready backpressure, so stages that each need an occasional scale-by-small-constant can use a single multiplier instead of one each.

---
 rtl/process_data_mul_pkg.sv | 26 ++
 rtl/process_data_mul_core.sv | 14 +
 rtl/process_data_rr_arb.sv | 34 +++
 rtl/process_data_mul_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/process_data_mul_pkg.sv
// Shared definitions for the process_data multiplier arbiter: operand and
// product widths of the shared multiplier core, the result-register state
// type and an index-width helper.
package process_data_mul_pkg;

    localparam int MUL_A_W = 29;
    localparam int MUL_B_W = 4;
    localparam int MUL_P_W = 32;

    // Result register occupancy; FULL means res_valid is asserted.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_t;

    // Ceiling log2 with a floor of 1, used to validate the index width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/process_data_mul_core.sv
// Shared 29-bit x 4-bit unsigned multiplier core with a 32-bit product.
// The mathematically 33-bit result is truncated to its low 32 bits.
module process_data_mul_core
    import process_data_mul_pkg::*;
(
    input  logic [MUL_A_W-1:0] a,
    input  logic [MUL_B_W-1:0] b,
    output logic [MUL_P_W-1:0] p
);

    // Multiplying in a 32-bit context drops product bit 32 by construction.
    assign p = MUL_P_W'(a) * MUL_P_W'(b);

endmodule

// File: rtl/process_data_rr_arb.sv
// Round-robin arbiter: grants the first asserted request found when
// searching upward from ptr with wrap, only while enable is high.
module process_data_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    // Priority search from the pointer position, first hit wins.
    always_comb begin
        int  cand;
        logic found;
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first, so no path leaves a signal unassigned (no latch).
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/process_data_mul_arbiter.sv
// Shares one 29x4 multiplier among NUM_REQ requesters. Round-robin grant,
// one-cycle registered result with requester index, valid/ready output and
// a count of results consumed downstream.
module process_data_mul_arbiter
    import process_data_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 32
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [NUM_REQ*MUL_A_W-1:0] req_a,
    input  logic [NUM_REQ*MUL_B_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [MUL_P_W-1:0]         res_data,
    output logic [ID_W-1:0]            res_id,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [CNT_W-1:0]           op_count
);

    if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end

    res_state_t         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               free;
    logic               transfer;
    logic               consume;
    logic [MUL_A_W-1:0] sel_a;
    logic [MUL_B_W-1:0] sel_b;
    logic [MUL_P_W-1:0] product;

    assign res_valid = (state == ST_FULL);
    assign consume   = res_valid & res_ready;
    // Output register can take a new result when empty or being drained now;
    // no grant is offered while reset is held.
    assign free      = ap_rst_n & (~res_valid | res_ready);
    assign transfer  = |grant;
    assign req_ready = grant;

    process_data_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .enable (free),
        .grant  (grant),
        .idx    (grant_idx)
    );

    // Operands of the granted requester feed the shared core.
    assign sel_a = req_a[int'(grant_idx)*MUL_A_W +: MUL_A_W];
    assign sel_b = req_b[int'(grant_idx)*MUL_B_W +: MUL_B_W];

    process_data_mul_core u_mul (
        .a (sel_a),
        .b (sel_b),
        .p (product)
    );

    // Result register, occupancy FSM, round-robin pointer and consume counter.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= ST_EMPTY;
            res_data <= '0;
            res_id   <= '0;
            rr_ptr   <= '0;
            op_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every register
            // samples pre-edge values regardless of statement order.
            case (state)
                ST_EMPTY: if (transfer) state <= ST_FULL;
                ST_FULL:  if (!transfer && res_ready) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase

            if (transfer) begin
                res_data <= product;
                res_id   <= grant_idx;
                rr_ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end

            if (consume) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
